// File: rtl/rv_pkg.sv
// rv_pkg: shared widths, ALU opcodes and operand-stage state encoding
package rv_pkg;
  localparam int XLEN = 64;
  localparam int REG_AW = 5;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4;
  localparam logic [3:0] SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, MUL = 4'd8, MULH = 4'd9;
  localparam logic [3:0] DIV = 4'd10, REM = 4'd11, SLT = 4'd12, SLTU = 4'd13;
  typedef enum logic [1:0] {EMPTY, FULL, HAZARD} state_t;
endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// fwd_mux: per-source MEM/WB bypass select plus load-use detection for that source
module fwd_mux import rv_pkg::*; #(
  parameter int W = XLEN,
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] i_rs,
  input  logic          i_used,
  input  logic [W-1:0]  i_rf_data,
  input  logic          i_mem_valid,
  input  logic          i_mem_reg_write,
  input  logic          i_mem_is_load,
  input  logic [AW-1:0] i_mem_rd,
  input  logic [W-1:0]  i_mem_data,
  input  logic          i_wb_valid,
  input  logic          i_wb_reg_write,
  input  logic [AW-1:0] i_wb_rd,
  input  logic [W-1:0]  i_wb_data,
  output logic [W-1:0]  o_fwd,
  output logic          o_load_use
);
  logic w_nz, w_mem_hit, w_wb_hit;
  // rs != 0 together with rd == rs already excludes x0 as a bypass target
  assign w_nz = i_rs != '0;
  assign w_mem_hit = w_nz && i_mem_valid && i_mem_reg_write && i_mem_rd == i_rs;
  assign w_wb_hit = w_nz && i_wb_valid && i_wb_reg_write && i_wb_rd == i_rs;
  assign o_fwd = (w_mem_hit && !i_mem_is_load) ? i_mem_data : w_wb_hit ? i_wb_data : i_rf_data;
  assign o_load_use = i_used && w_mem_hit && i_mem_is_load;
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register with forwarding and load-use stall; OPSTAGE_PERF_EN adds hazard/backpressure counters
module alu_operand_stage #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int REG_AW = rv_pkg::REG_AW
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_rs1_used,
  input  logic              in_rs2_used,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_pc,
  input  logic              in_use_imm,
  input  logic [3:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              mem_fwd_valid,
  input  logic              mem_fwd_reg_write,
  input  logic              mem_fwd_is_load,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic              wb_fwd_reg_write,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   X,
  output logic [XLEN-1:0]   Y,
  output logic [3:0]        OP,
  output logic [XLEN-1:0]   store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write
`ifdef OPSTAGE_PERF_EN
  ,
  output logic [31:0]       hazard_cycles,
  output logic [31:0]       backpressure_cycles
`endif
);
  import rv_pkg::*;
  state_t r_state;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0] r_rs1_data, r_rs2_data, r_pc, r_imm;
  logic [3:0] r_op;
  logic r_rs1_used, r_rs2_used, r_use_pc, r_use_imm, r_reg_write, r_mem_read, r_mem_write;
  logic [XLEN-1:0] w_fwd1, w_fwd2;
  logic w_lu1, w_lu2, w_held, w_hazard, w_accept;
  fwd_mux #(.W(XLEN), .AW(REG_AW)) u_fwd1 (
    .i_rs(r_rs1), .i_used(r_rs1_used), .i_rf_data(r_rs1_data),
    .i_mem_valid(mem_fwd_valid), .i_mem_reg_write(mem_fwd_reg_write), .i_mem_is_load(mem_fwd_is_load),
    .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
    .i_wb_valid(wb_fwd_valid), .i_wb_reg_write(wb_fwd_reg_write), .i_wb_rd(wb_fwd_rd), .i_wb_data(wb_fwd_data),
    .o_fwd(w_fwd1), .o_load_use(w_lu1)
  );
  fwd_mux #(.W(XLEN), .AW(REG_AW)) u_fwd2 (
    .i_rs(r_rs2), .i_used(r_rs2_used), .i_rf_data(r_rs2_data),
    .i_mem_valid(mem_fwd_valid), .i_mem_reg_write(mem_fwd_reg_write), .i_mem_is_load(mem_fwd_is_load),
    .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
    .i_wb_valid(wb_fwd_valid), .i_wb_reg_write(wb_fwd_reg_write), .i_wb_rd(wb_fwd_rd), .i_wb_data(wb_fwd_data),
    .o_fwd(w_fwd2), .o_load_use(w_lu2)
  );
  assign w_held = r_state != EMPTY;
  assign w_hazard = w_held && (w_lu1 || w_lu2);
  assign out_valid = w_held && !w_hazard;
  assign in_ready = !flush && (!w_held || (out_valid && out_ready));
  assign w_accept = in_valid && in_ready;
  assign X = r_use_pc ? r_pc : w_fwd1;
  assign Y = r_use_imm ? r_imm : w_fwd2;
  assign store_data = w_fwd2;
  assign OP = r_op;
  assign out_rd = r_rd;
  assign out_reg_write = r_reg_write;
  assign out_mem_read = r_mem_read;
  assign out_mem_write = r_mem_write;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= EMPTY;
      {r_rs1, r_rs2, r_rd, r_op} <= '0;
      {r_rs1_data, r_rs2_data, r_pc, r_imm} <= '0;
      {r_rs1_used, r_rs2_used, r_use_pc, r_use_imm, r_reg_write, r_mem_read, r_mem_write} <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else if (w_accept) begin
      r_state <= FULL;
      {r_rs1, r_rs2, r_rd, r_op} <= {in_rs1, in_rs2, in_rd, in_op};
      {r_rs1_data, r_rs2_data, r_pc, r_imm} <= {in_rs1_data, in_rs2_data, in_pc, in_imm};
      {r_rs1_used, r_rs2_used, r_use_pc, r_use_imm} <= {in_rs1_used, in_rs2_used, in_use_pc, in_use_imm};
      {r_reg_write, r_mem_read, r_mem_write} <= {in_reg_write, in_mem_read, in_mem_write};
    end else if (out_valid && out_ready) begin
      r_state <= EMPTY;
    end else if (w_held) begin
      r_state <= w_hazard ? HAZARD : FULL;
    end
  end
`ifdef OPSTAGE_PERF_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hazard_cycles <= '0;
      backpressure_cycles <= '0;
    end else begin
      if (w_hazard && hazard_cycles != '1) hazard_cycles <= hazard_cycles + 32'd1;
      if (out_valid && !out_ready && backpressure_cycles != '1) backpressure_cycles <= backpressure_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed test-plan steps plus random traffic against a behavioural model
module tb_alu_operand_stage;
  import rv_pkg::*;
  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [63:0] d1, d2, pc, imm;
    logic upc, uimm;
    logic [3:0] op;
    logic [4:0] rd;
    logic rw, mr, mw;
  } ins_t;
  logic clk = 0, rst = 1, flush = 0, iv = 0, ordy = 1;
  ins_t cur = '0;
  logic mv = 0, mrw = 0, mld = 0, wv = 0, wrw = 0;
  logic [4:0] mrd = 0, wrd = 0;
  logic [63:0] mdata = 0, wdata = 0;
  logic in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic [63:0] X, Y, store_data;
  logic [3:0] OP;
  logic [4:0] out_rd;
  int n_vec = 0, n_err = 0;
  logic m_held = 0;
  ins_t m_i = '0;
  logic [31:0] m_hc = 0, m_bc = 0;
  logic [63:0] s_x, s_y, s_sd;
  logic [3:0] s_op;
`ifdef OPSTAGE_PERF_EN
  logic [31:0] hazard_cycles, backpressure_cycles;
`endif
  always #5 clk = ~clk;
  alu_operand_stage dut (
    .CLK(clk), .RESET(rst), .flush(flush), .in_valid(iv), .in_ready(in_ready),
    .in_rs1(cur.rs1), .in_rs2(cur.rs2), .in_rs1_used(cur.u1), .in_rs2_used(cur.u2),
    .in_rs1_data(cur.d1), .in_rs2_data(cur.d2), .in_pc(cur.pc), .in_imm(cur.imm),
    .in_use_pc(cur.upc), .in_use_imm(cur.uimm), .in_op(cur.op), .in_rd(cur.rd),
    .in_reg_write(cur.rw), .in_mem_read(cur.mr), .in_mem_write(cur.mw),
    .mem_fwd_valid(mv), .mem_fwd_reg_write(mrw), .mem_fwd_is_load(mld), .mem_fwd_rd(mrd), .mem_fwd_data(mdata),
    .wb_fwd_valid(wv), .wb_fwd_reg_write(wrw), .wb_fwd_rd(wrd), .wb_fwd_data(wdata),
    .out_valid(out_valid), .out_ready(ordy), .X(X), .Y(Y), .OP(OP), .store_data(store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write)
`ifdef OPSTAGE_PERF_EN
    , .hazard_cycles(hazard_cycles), .backpressure_cycles(backpressure_cycles)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] fwd(input logic [4:0] rs, input logic [63:0] rf);
    if (rs != 0 && mv && mrw && !mld && mrd != 0 && mrd == rs) return mdata;
    if (rs != 0 && wv && wrw && wrd != 0 && wrd == rs) return wdata;
    return rf;
  endfunction
  function automatic logic m_hz();
    return m_held && mv && mld && mrw && mrd != 0 &&
           ((m_i.u1 && m_i.rs1 == mrd) || (m_i.u2 && m_i.rs2 == mrd));
  endfunction
  function automatic logic m_ov();
    return m_held && !m_hz();
  endfunction
  function automatic logic m_ir();
    return !flush && (!m_held || (m_ov() && ordy));
  endfunction
  task automatic check_all();
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov()});
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_ir()});
    if (m_held) begin
      chk("X", X, m_i.upc ? m_i.pc : fwd(m_i.rs1, m_i.d1));
      chk("Y", Y, m_i.uimm ? m_i.imm : fwd(m_i.rs2, m_i.d2));
      chk("store_data", store_data, fwd(m_i.rs2, m_i.d2));
      chk("OP", {60'd0, OP}, {60'd0, m_i.op});
      chk("out_rd", {59'd0, out_rd}, {59'd0, m_i.rd});
      chk("ctl", {61'd0, out_reg_write, out_mem_read, out_mem_write}, {61'd0, m_i.rw, m_i.mr, m_i.mw});
    end
  endtask
  task automatic tick();
    logic ir, ov, hz;
    @(negedge clk);
    check_all();
    hz = m_hz();
    ov = m_ov();
    ir = m_ir();
    @(posedge clk);
    if (rst) begin
      m_held = 0;
      m_i = '0;
      m_hc = 0;
      m_bc = 0;
    end else begin
      if (hz && m_hc != 32'hFFFFFFFF) m_hc++;
      if (ov && !ordy && m_bc != 32'hFFFFFFFF) m_bc++;
      if (flush) m_held = 0;
      else if (iv && ir) begin
        m_held = 1;
        m_i = cur;
      end else if (ov && ordy) m_held = 0;
    end
    #1;
  endtask
  function automatic ins_t mk(input logic [4:0] a, input logic [4:0] b, input logic [63:0] da,
                              input logic [63:0] db, input logic [4:0] rd, input logic [3:0] op);
    ins_t t = '0;
    t.rs1 = a; t.rs2 = b; t.d1 = da; t.d2 = db; t.rd = rd; t.op = op;
    t.u1 = 1; t.u2 = 1; t.rw = 1;
    return t;
  endfunction
  initial begin
    rst = 1;
    tick();
    tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_X", X, 64'd0);
    chk("rst_Y", Y, 64'd0);
    chk("rst_sd", store_data, 64'd0);
    chk("rst_OP_rd", {55'd0, OP, out_rd}, 64'd0);
    chk("rst_ctl", {61'd0, out_reg_write, out_mem_read, out_mem_write}, 64'd0);
    rst = 0;
    cur = mk(1, 2, 64'd5, 64'd7, 3, ADD);
    iv = 1;
    tick();
    iv = 0;
    ordy = 0;
    chk("cap_valid", {63'd0, out_valid}, 64'd1);
    chk("cap_X", X, 64'd5);
    chk("cap_Y", Y, 64'd7);
    chk("cap_OP", {60'd0, OP}, 64'd0);
    chk("cap_rd", {59'd0, out_rd}, 64'd3);
    tick();
    ordy = 1;
    tick();
    cur = mk(4, 2, 64'h11, 64'h22, 5, ADD);
    iv = 1;
    ordy = 0;
    tick();
    iv = 0;
    {mv, mrw, mld, mrd, mdata} = {1'b1, 1'b1, 1'b0, 5'd4, 64'h100};
    {wv, wrw, wrd, wdata} = {1'b1, 1'b1, 5'd4, 64'h200};
    #1 chk("mem_prio", X, 64'h100);
    tick();
    mv = 0;
    #1 chk("wb_fwd", X, 64'h200);
    ordy = 1;
    tick();
    wv = 0;
    cur = mk(1, 6, 64'h1, 64'h2, 7, SUB);
    iv = 1;
    tick();
    iv = 0;
    {mv, mrw, mld, mrd} = {1'b1, 1'b1, 1'b1, 5'd6};
    #1 chk("lu_valid", {63'd0, out_valid}, 64'd0);
    chk("lu_ready", {63'd0, in_ready}, 64'd0);
    tick();
    mv = 0;
    {wv, wrw, wrd, wdata} = {1'b1, 1'b1, 5'd6, 64'hDEAD};
    #1 chk("lu_Y", Y, 64'hDEAD);
    chk("lu_valid2", {63'd0, out_valid}, 64'd1);
    tick();
    wv = 0;
    cur = mk(0, 3, 64'd0, 64'd9, 8, ADD);
    cur.uimm = 1;
    cur.imm = -64'sd4;
    iv = 1;
    tick();
    iv = 0;
    {mv, mrw, mld, mrd, mdata} = {1'b1, 1'b1, 1'b0, 5'd0, 64'hFF};
    #1 chk("x0_X", X, 64'd0);
    chk("imm_Y", Y, 64'hFFFFFFFFFFFFFFFC);
    tick();
    mv = 0;
    cur = mk(1, 2, 64'hA, 64'hB, 4, SUB);
    iv = 1;
    tick();
    cur = mk(3, 5, 64'hC, 64'hD, 9, OR);
    ordy = 0;
    s_x = X; s_y = Y; s_sd = store_data; s_op = OP;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_X", X, s_x);
      chk("bp_Y", Y, s_y);
      chk("bp_sd", store_data, s_sd);
      chk("bp_OP", {60'd0, OP}, {60'd0, s_op});
      chk("bp_ready", {62'd0, out_valid, in_ready}, 64'd2);
    end
    ordy = 1;
    #1 chk("bp_release", {63'd0, in_ready}, 64'd1);
    tick();
    iv = 0;
    chk("nobubble_valid", {63'd0, out_valid}, 64'd1);
    chk("nobubble_OP", {60'd0, OP}, {60'd0, OR});
    chk("nobubble_rd", {59'd0, out_rd}, 64'd9);
    ordy = 0;
    flush = 1;
    iv = 1;
    cur = mk(1, 1, 64'h1, 64'h1, 12, XOR);
    #1 chk("flush_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 0;
    iv = 0;
    ordy = 1;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("flush_nocap", {63'd0, out_valid}, 64'd0);
    cur = mk(2, 2, 64'h3, 64'h3, 1, ADD);
    iv = 1;
    tick();
    iv = 0;
    {mv, mrw, mld, mrd} = {1'b1, 1'b1, 1'b1, 5'd2};
    tick();
    rst = 1;
    tick();
    rst = 0;
    mv = 0;
    chk("rst_hazard", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 600; i++) begin
      cur.rs1 = 5'($urandom_range(0, 7)); cur.rs2 = 5'($urandom_range(0, 7));
      cur.u1 = 1'($urandom); cur.u2 = 1'($urandom);
      cur.d1 = {$urandom, $urandom}; cur.d2 = {$urandom, $urandom};
      cur.pc = {$urandom, $urandom}; cur.imm = {$urandom, $urandom};
      cur.upc = 1'($urandom); cur.uimm = 1'($urandom);
      cur.op = 4'($urandom_range(0, 13)); cur.rd = 5'($urandom_range(0, 7));
      {cur.rw, cur.mr, cur.mw} = 3'($urandom);
      iv = 1'($urandom);
      ordy = ($urandom % 4) != 0;
      flush = ($urandom % 16) == 0;
      rst = ($urandom % 64) == 0;
      {mv, mrw, mld} = 3'($urandom);
      mrd = 5'($urandom_range(0, 7));
      mdata = {$urandom, $urandom};
      {wv, wrw} = 2'($urandom);
      wrd = 5'($urandom_range(0, 7));
      wdata = {$urandom, $urandom};
      tick();
    end
`ifdef OPSTAGE_PERF_EN
    chk("hazard_cycles", {32'd0, hazard_cycles}, {32'd0, m_hc});
    chk("backpressure_cycles", {32'd0, backpressure_cycles}, {32'd0, m_bc});
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage for the RV64IM core. Sits directly upstream of the ALU.
- Registers one decoded instruction and applies operand forwarding from the MEM and WB stages.
- Selects PC/immediate operands and drives the ALU X, Y and OP inputs.
- Detects load-use hazards and inserts bubbles; uses a valid/ready handshake on both sides.

Parameters:
- XLEN, 64, datapath width of operands, PC, immediate and forwarded results.
- REG_AW, 5, register address width.

Ports:
- CLK  input  1  core clock
- RESET  input  1  synchronous, active-high reset
- flush  input  1  kill held instruction (branch/exception redirect)
- in_valid  input  1  decode offers an instruction
- in_ready  output  1  stage can accept this cycle
- in_rs1, in_rs2  input  REG_AW each  source register addresses
- in_rs1_used, in_rs2_used  input  1 each  source actually read
- in_rs1_data, in_rs2_data  input  XLEN each  register-file read data
- in_pc, in_imm  input  XLEN each  PC and sign-extended immediate
- in_use_pc, in_use_imm  input  1 each  X=PC / Y=imm select
- in_op  input  4  ALU opcode (0 add … 13 sltu)
- in_rd  input  REG_AW  destination register
- in_reg_write, in_mem_read, in_mem_write  input  1 each  control bits
- mem_fwd_valid, mem_fwd_reg_write, mem_fwd_is_load  input  1 each  MEM-stage status
- mem_fwd_rd  input  REG_AW  MEM-stage destination
- mem_fwd_data  input  XLEN  MEM-stage ALU result
- wb_fwd_valid, wb_fwd_reg_write  input  1 each  WB-stage status
- wb_fwd_rd  input  REG_AW  WB-stage destination
- wb_fwd_data  input  XLEN  WB write data
- out_valid  output  1  X/Y/OP valid to ALU
- out_ready  input  1  downstream (EX/MEM) accepts
- X, Y  output  XLEN each  ALU operands
- OP  output  4  ALU opcode
- store_data  output  XLEN  forwarded rs2 value for stores
- out_rd  output  REG_AW
- out_reg_write, out_mem_read, out_mem_write  output  1 each

Behaviour:
- Reset and interface: one clock; reset is synchronous and active-high. On RESET, state goes to EMPTY and all held fields clear. out_valid, out_reg_write, out_mem_read and out_mem_write are 0. X, Y, store_data, OP and out_rd read 0.
- States:
  - EMPTY: nothing held.
  - FULL: instruction held, no hazard.
  - HAZARD: instruction held, load-use pending.
- Hazard term: hazard = held && mem_fwd_valid && mem_fwd_is_load && mem_fwd_reg_write && mem_fwd_rd!=0 && ((rs1_used && rs1==mem_fwd_rd) || (rs2_used && rs2==mem_fwd_rd)). It is evaluated combinationally each cycle. The state reflects it and HAZARD returns to FULL when hazard deasserts.
- out_valid = held && !hazard.
- in_ready = EMPTY || (out_valid && out_ready).
- Capture: in_valid && in_ready loads the instruction next cycle; latency is 1 cycle from accept to out_valid if no hazard.
- Simultaneous hand-off and accept: the new instruction replaces the old one with no bubble.
- Forwarding per source, evaluated combinationally on held rs addresses:
  - MEM match (valid, reg_write, !is_load, rd!=0, rd==rs) wins.
  - Otherwise WB match (valid, reg_write, rd!=0, rd==rs).
  - Otherwise captured register-file data.
  - x0 is never forwarded.
- Operand select: X = use_pc ? pc : fwd_rs1. Y = use_imm ? imm : fwd_rs2. store_data = fwd_rs2 always.
- Arithmetic: no arithmetic in this block. OP passes through unchanged.
- flush:
  - Next state is EMPTY regardless of in_valid, out_ready or hazard; flush beats a same-cycle accept.
  - in_ready is forced 0 during the flush cycle.
  - The killed instruction never shows out_valid after the flush cycle.
- Backpressure: while out_valid && !out_ready, all outputs hold stable. Forwarded values may change only if the forwarding buses change.
- RESET mid-HAZARD or mid-stall: RESET wins; the instruction is dropped.

Optional Feature:
- Macro OPSTAGE_PERF_EN.
- Defined:
  - Adds output ports hazard_cycles and backpressure_cycles, 32 bits each. They count cycles in HAZARD and cycles with out_valid && !out_ready.
  - The counters saturate at 0xFFFFFFFF and clear on RESET only.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package rv_pkg:
  - XLEN and REG_AW constants.
  - ALU opcode localparams: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, MUL=8, MULH=9, DIV=10, REM=11, SLT=12, SLTU=13.
  - State enum typedef for EMPTY/FULL/HAZARD.
- Sub-module fwd_mux, instantiated twice (rs1, rs2): inputs rs, used, rf_data, MEM/WB forwarding buses; outputs the forwarded value.

Test Plan:
- Basic capture: RESET, then accept add x3,x1,x2 with rs1_data=5, rs2_data=7. Next cycle out_valid=1, X=5, Y=7, OP=0, out_rd=3.
- MEM priority: held rs1=x4, MEM fwd rd=4 data=0x100 (non-load), WB fwd rd=4 data=0x200. Then X=0x100; drop MEM and X=0x200.
- Load-use: MEM is_load rd=6, held rs2=6. out_valid=0 and in_ready=0 for that cycle. Next cycle the load is gone and WB rd=6 data=0xDEAD gives Y=0xDEAD, out_valid=1.
- x0 and immediate: rs1=x0 with MEM rd=0 data=0xFF gives X=rf_data (0). use_imm with imm=-4 gives Y=0xFFFFFFFFFFFFFFFC.
- Backpressure: out_ready=0 for 3 cycles gives outputs stable and in_ready=0. Set out_ready=1 with in_valid=1 and the next instruction appears the following cycle with no bubble.
- Flush vs accept: flush=1 with in_valid=1 in the same cycle gives in_ready=0, out_valid=0 next cycle, and the new instruction is not captured.
